// File: rtl/fme_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fme_pkg
// Purpose  : Shared definitions for the half-pel interpolation engine:
//            H.264 6-tap filter taps, 3x3 grid indices, FSM states and the
//            round/clip helper.
// Revision : 1.0  initial release
// ============================================================================
package fme_pkg;

    // H.264 luma half-pel filter taps (1, -5, 20, 20, -5, 1)
    localparam int TAP0 = 1;
    localparam int TAP1 = -5;
    localparam int TAP2 = 20;
    localparam int TAP3 = 20;
    localparam int TAP4 = -5;
    localparam int TAP5 = 1;

    // Grid index k = 3*dy + dx
    localparam int G_UL = 0;
    localparam int G_U  = 1;
    localparam int G_UR = 2;
    localparam int G_L  = 3;
    localparam int G_C  = 4;
    localparam int G_R  = 5;
    localparam int G_DL = 6;
    localparam int G_D  = 7;
    localparam int G_DR = 8;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_HPASS = 3'd1,
        ST_VPASS = 3'd2,
        ST_DPASS = 3'd3,
        ST_DRAIN = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    // Add half an LSB, arithmetic shift, then saturate to [0, 2^pw-1]
    function automatic logic [31:0] round_clip(input logic signed [31:0] v,
                                               input int sh,
                                               input int pw);
        logic signed [31:0] t;
        logic signed [31:0] maxv;
        maxv = (32'sd1 <<< pw) - 32'sd1;
        t    = (v + (32'sd1 <<< (sh - 1))) >>> sh;
        if (t < 0)
            return '0;
        if (t > maxv)
            return maxv;
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/six_tap_fir.sv
`default_nettype none
// ============================================================================
// Module   : six_tap_fir
// Purpose  : Registered 6-tap FIR (1,-5,20,20,-5,1) on signed inputs. One
//            result per cycle, one cycle of latency.
// Revision : 1.0  initial release
// ============================================================================
module six_tap_fir
    import fme_pkg::*;
#(
    parameter int IN_W  = 15,
    parameter int OUT_W = 22
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  i_x0,
    input  logic signed [IN_W-1:0]  i_x1,
    input  logic signed [IN_W-1:0]  i_x2,
    input  logic signed [IN_W-1:0]  i_x3,
    input  logic signed [IN_W-1:0]  i_x4,
    input  logic signed [IN_W-1:0]  i_x5,
    output logic signed [OUT_W-1:0] o_y
);

    localparam logic signed [OUT_W-1:0] c_t0 = OUT_W'(TAP0);
    localparam logic signed [OUT_W-1:0] c_t1 = OUT_W'(TAP1);
    localparam logic signed [OUT_W-1:0] c_t2 = OUT_W'(TAP2);
    localparam logic signed [OUT_W-1:0] c_t3 = OUT_W'(TAP3);
    localparam logic signed [OUT_W-1:0] c_t4 = OUT_W'(TAP4);
    localparam logic signed [OUT_W-1:0] c_t5 = OUT_W'(TAP5);

    logic signed [OUT_W-1:0] w_y_d;
    logic signed [OUT_W-1:0] r_y_q;

    // Weighted sum at full accumulator width; inputs are sign-extended first
    always_comb begin
        w_y_d = OUT_W'(i_x0) * c_t0 + OUT_W'(i_x1) * c_t1 + OUT_W'(i_x2) * c_t2
              + OUT_W'(i_x3) * c_t3 + OUT_W'(i_x4) * c_t4 + OUT_W'(i_x5) * c_t5;
    end

    // Output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_y_q <= '0;
        else
            r_y_q <= w_y_d;
    end

    assign o_y = r_y_q;

endmodule
`default_nettype wire

// File: rtl/half_pel_interp_engine.sv
`default_nettype none
// ============================================================================
// Module   : half_pel_interp_engine
// Purpose  : Loads a WIN x WIN integer window, then runs 20 filter ops on a
//            single shared 6-tap FIR to produce the 3x3 half-pel grid
//            (8 half-pel candidates + integer centre).
// Revision : 1.0  initial release
// ============================================================================
module half_pel_interp_engine
    import fme_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int WIN   = 8,
    parameter int CTR   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_pix,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [9*PIX_W-1:0] out_grid
);

    localparam int c_iw    = PIX_W + 7;
    localparam int c_acc_w = PIX_W + 14;
    localparam int c_npix  = WIN * WIN;
    localparam int c_idx_w = $clog2(c_npix);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_npix - 1);
    localparam logic [c_idx_w-1:0] c_ctr_idx  = c_idx_w'(CTR * WIN + CTR);

    state_t                    r_state_q, w_state_d;
    logic [c_idx_w-1:0]        r_cnt_q, w_cnt_d;
    logic [4:0]                r_op_q, w_op_d;
    logic                      r_pend_vld_q, w_pend_vld_d;
    logic [4:0]                r_pend_op_q;
    logic [PIX_W-1:0]          r_win_q [c_npix];
    logic signed [c_iw-1:0]    r_lb1_q [7], w_lb1_d [7];
    logic signed [c_iw-1:0]    r_rb1_q [7], w_rb1_d [7];
    logic [PIX_W-1:0]          r_grid_q [9], w_grid_d [9];
    logic signed [c_iw-1:0]    w_tap [6];
    logic [c_idx_w-1:0]        w_pidx [6];
    logic [2:0]                w_iidx [6];
    logic signed [c_acc_w-1:0] w_fir_y;
    logic [PIX_W-1:0]          w_rnd5, w_rnd10;

    assign in_ready  = (r_state_q == ST_LOAD);
    assign out_valid = (r_state_q == ST_OUT);

    // Next state and op scheduling; r_op_q counts the 20 filter ops 0..19
    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_op_d       = r_op_q;
        w_pend_vld_d = (r_state_q == ST_HPASS) || (r_state_q == ST_VPASS) ||
                       (r_state_q == ST_DPASS);
        case (r_state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    if (r_cnt_q == c_last_idx) begin
                        w_cnt_d   = '0;
                        w_op_d    = '0;
                        w_state_d = ST_HPASS;
                    end else begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                end
            end
            ST_HPASS: begin
                w_op_d = r_op_q + 5'd1;
                if (r_op_q == 5'd13)
                    w_state_d = ST_VPASS;
            end
            ST_VPASS: begin
                w_op_d = r_op_q + 5'd1;
                if (r_op_q == 5'd15)
                    w_state_d = ST_DPASS;
            end
            ST_DPASS: begin
                w_op_d = r_op_q + 5'd1;
                if (r_op_q == 5'd19)
                    w_state_d = ST_DRAIN;
            end
            ST_DRAIN: w_state_d = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    w_state_d = ST_LOAD;
                    w_op_d    = '0;
                end
            end
            default: w_state_d = ST_LOAD;
        endcase
    end

    // FIR input mux: ops 0..13 horizontal (row pairs L/R), 14..15 vertical
    // at the centre column, 16..19 vertical over the stored intermediates
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            if (r_op_q < 5'd14)
                w_pidx[i] = c_idx_w'((CTR - 3 + int'(r_op_q >> 1)) * WIN +
                                     CTR - 3 + int'(r_op_q[0]) + i);
            else
                w_pidx[i] = c_idx_w'((CTR - 3 + int'(r_op_q) - 14 + i) * WIN + CTR);
            w_iidx[i] = 3'(int'(r_op_q[0]) + i);
            if (r_op_q < 5'd16)
                w_tap[i] = {{7{1'b0}}, r_win_q[w_pidx[i]]};
            else if (r_op_q < 5'd18)
                w_tap[i] = r_lb1_q[w_iidx[i]];
            else
                w_tap[i] = r_rb1_q[w_iidx[i]];
        end
    end

    six_tap_fir #(
        .IN_W  (c_iw),
        .OUT_W (c_acc_w)
    ) u_fir (
        .clk  (clk),
        .rst  (rst),
        .i_x0 (w_tap[0]),
        .i_x1 (w_tap[1]),
        .i_x2 (w_tap[2]),
        .i_x3 (w_tap[3]),
        .i_x4 (w_tap[4]),
        .i_x5 (w_tap[5]),
        .o_y  (w_fir_y)
    );

    assign w_rnd5  = PIX_W'(round_clip(32'(w_fir_y), 5, PIX_W));
    assign w_rnd10 = PIX_W'(round_clip(32'(w_fir_y), 10, PIX_W));

    // Retire the op issued last cycle into intermediates and the output grid
    always_comb begin
        w_lb1_d  = r_lb1_q;
        w_rb1_d  = r_rb1_q;
        w_grid_d = r_grid_q;
        if (r_state_q == ST_HPASS && r_op_q == 5'd0)
            w_grid_d[G_C] = r_win_q[c_ctr_idx];
        if (r_pend_vld_q) begin
            if (r_pend_op_q < 5'd14) begin
                if (r_pend_op_q[0])
                    w_rb1_d[r_pend_op_q[3:1]] = w_fir_y[c_iw-1:0];
                else
                    w_lb1_d[r_pend_op_q[3:1]] = w_fir_y[c_iw-1:0];
                // Intermediate row index 3 is the centre row: L and R
                if (r_pend_op_q[3:1] == 3'd3) begin
                    if (r_pend_op_q[0])
                        w_grid_d[G_R] = w_rnd5;
                    else
                        w_grid_d[G_L] = w_rnd5;
                end
            end else begin
                case (r_pend_op_q)
                    5'd14:   w_grid_d[G_U]  = w_rnd5;
                    5'd15:   w_grid_d[G_D]  = w_rnd5;
                    5'd16:   w_grid_d[G_UL] = w_rnd10;
                    5'd17:   w_grid_d[G_DL] = w_rnd10;
                    5'd18:   w_grid_d[G_UR] = w_rnd10;
                    5'd19:   w_grid_d[G_DR] = w_rnd10;
                    default: ;
                endcase
            end
        end
    end

    // Window storage; contents are only meaningful once a window is loaded
    always_ff @(posedge clk) begin
        if (r_state_q == ST_LOAD && in_valid)
            r_win_q[r_cnt_q] <= in_pix;
    end

    // Control, intermediate and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q    <= ST_LOAD;
            r_cnt_q      <= '0;
            r_op_q       <= '0;
            r_pend_vld_q <= 1'b0;
            r_pend_op_q  <= '0;
            for (int i = 0; i < 7; i++) begin
                r_lb1_q[i] <= '0;
                r_rb1_q[i] <= '0;
            end
            for (int k = 0; k < 9; k++)
                r_grid_q[k] <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_op_q       <= w_op_d;
            r_pend_vld_q <= w_pend_vld_d;
            r_pend_op_q  <= r_op_q;
            r_lb1_q      <= w_lb1_d;
            r_rb1_q      <= w_rb1_d;
            r_grid_q     <= w_grid_d;
        end
    end

    // Flatten the grid onto the output bus
    always_comb begin
        for (int k = 0; k < 9; k++)
            out_grid[k*PIX_W +: PIX_W] = r_grid_q[k];
    end

endmodule
`default_nettype wire

// File: tb/tb_half_pel_interp_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_half_pel_interp_engine
// Purpose  : Self-checking bench: directed vector table, backpressure, reset
//            aborts and random windows against a behavioural filter model.
// Revision : 1.0  initial release
// ============================================================================
module tb_half_pel_interp_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pix;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_grid;

    always #5 clk = ~clk;

    half_pel_interp_engine #(.PIX_W(8), .WIN(8), .CTR(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_grid  (out_grid)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] tb_win [64];

    typedef struct {
        int          kind;   // 0 flat, 1 h-ramp, 2 saturation, 3 v-ramp
        int          gaps;   // random in_valid gaps
        int          hold;   // cycles out_ready held low while out_valid
        int          junk;   // drive in_valid during compute
        int          early;  // out_ready high before out_valid
        logic [71:0] exp;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] pk(input int ul, input int u, input int ur,
                                       input int l, input int c, input int r,
                                       input int dl, input int d, input int dr);
        return {8'(dr), 8'(d), 8'(dl), 8'(r), 8'(c), 8'(l), 8'(ur), 8'(u), 8'(ul)};
    endfunction

    task automatic build(input int kind);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                case (kind)
                    0:       tb_win[r*8+c] = 8'd100;
                    1:       tb_win[r*8+c] = 8'(10 * c);
                    2:       tb_win[r*8+c] = (c == 2 || c == 3) ? 8'd255 : 8'd0;
                    3:       tb_win[r*8+c] = 8'(10 * r);
                    default: tb_win[r*8+c] = 8'($urandom_range(0, 255));
                endcase
    endtask

    // Behavioural H.264 half-pel model for WIN=8, CTR=3
    function automatic int px(input int r, input int c);
        return int'(tb_win[r*8+c]);
    endfunction

    function automatic int hb(input int r, input int c0);
        return px(r,c0) - 5*px(r,c0+1) + 20*px(r,c0+2) + 20*px(r,c0+3)
             - 5*px(r,c0+4) + px(r,c0+5);
    endfunction

    function automatic int vb(input int r0, input int c);
        return px(r0,c) - 5*px(r0+1,c) + 20*px(r0+2,c) + 20*px(r0+3,c)
             - 5*px(r0+4,c) + px(r0+5,c);
    endfunction

    function automatic int jb(input int r0, input int c0);
        return hb(r0,c0) - 5*hb(r0+1,c0) + 20*hb(r0+2,c0) + 20*hb(r0+3,c0)
             - 5*hb(r0+4,c0) + hb(r0+5,c0);
    endfunction

    function automatic int clp(input int v, input int sh);
        int t;
        t = (v + (1 << (sh - 1))) >>> sh;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        return t;
    endfunction

    function automatic logic [71:0] model_grid();
        return pk(clp(jb(0,0),10), clp(vb(0,3),5), clp(jb(0,1),10),
                  clp(hb(3,0),5),  px(3,3),        clp(hb(3,1),5),
                  clp(jb(1,0),10), clp(vb(1,3),5), clp(jb(1,1),10));
    endfunction

    // Send the first n pixels of tb_win; called and returns at a negedge
    task automatic send_window(input int n, input int gaps);
        logic acc;
        int   tries;
        for (int idx = 0; idx < n; idx++) begin
            in_pix   = tb_win[idx];
            in_valid = 1'b1;
            tries    = 0;
            acc      = 1'b0;
            while (!acc && tries < 50) begin
                acc = in_ready;
                @(posedge clk);
                @(negedge clk);
                tries++;
            end
            if (!acc)
                chk("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            if (gaps != 0 && idx != n - 1)
                repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic run_check(input string nm, input int gaps, input int hold,
                             input int junk, input int early, input logic [71:0] exp);
        int          n;
        logic [71:0] g;
        if (early != 0)
            out_ready = 1'b1;
        send_window(64, gaps);
        if (junk != 0) begin
            in_valid = 1'b1;
            in_pix   = 8'hAA;
        end
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({nm, "_latency"}, n, 21);
        for (int k = 0; k < 9; k++)
            chk($sformatf("%s_grid%0d", nm, k), 32'(out_grid[k*8 +: 8]), 32'(exp[k*8 +: 8]));
        g = out_grid;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, 32'(out_valid), 1);
            chk({nm, "_hold_grid"}, 32'(out_grid == g), 1);
            chk({nm, "_hold_in_ready"}, 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_post_in_ready"}, 32'(in_ready), 1);
        chk({nm, "_post_out_valid"}, 32'(out_valid), 0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_pix    = '0;
        out_ready = 1'b0;

        vecs[0] = '{kind: 0, gaps: 0, hold: 0, junk: 0, early: 0,
                    exp: pk(100,100,100, 100,100,100, 100,100,100)};
        vecs[1] = '{kind: 1, gaps: 1, hold: 5, junk: 1, early: 0,
                    exp: pk(25,30,35, 25,30,35, 25,30,35)};
        vecs[2] = '{kind: 2, gaps: 0, hold: 0, junk: 0, early: 1,
                    exp: pk(255,255,120, 255,255,120, 255,255,120)};
        vecs[3] = '{kind: 3, gaps: 1, hold: 2, junk: 0, early: 0,
                    exp: pk(25,25,25, 30,30,30, 35,35,35)};

        repeat (2) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_grid", 32'(out_grid == 72'd0), 1);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            build(vecs[v].kind);
            run_check($sformatf("vec%0d", v), vecs[v].gaps, vecs[v].hold,
                      vecs[v].junk, vecs[v].early, vecs[v].exp);
        end

        // Abort mid-load: 30 saturation pixels, then a clean ramp window
        build(2);
        send_window(30, 0);
        rst = 1'b0;
        #1;
        chk("midload_rst_in_ready", 32'(in_ready), 1);
        chk("midload_rst_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        build(1);
        run_check("after_midload", 0, 0, 0, 0, pk(25,30,35, 25,30,35, 25,30,35));

        // Abort mid-compute: full saturation window, reset during HPASS
        build(2);
        send_window(64, 0);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midcomp_rst_out_valid", 32'(out_valid), 0);
        rst = 1'b1;
        @(negedge clk);
        build(0);
        run_check("after_midcomp", 0, 0, 0, 0, pk(100,100,100, 100,100,100, 100,100,100));

        // Random windows against the behavioural model
        for (int t = 0; t < 4; t++) begin
            build(4);
            run_check($sformatf("rand%0d", t), 1, int'($urandom_range(0, 3)), 0, 0,
                      model_grid());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
